// File: rtl/fib_stack.sv
// fib_stack: handshaked LIFO frame stack for the Fibonacci controller
// Ports: clk/rst (sync, active-high); pushSig/popSig/pushData request side, held until readySig;
// popData last popped frame; readySig one-cycle completion pulse; count/empty/full occupancy;
// ovf/udf sticky error flags, cleared only by rst.
module fib_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pushSig,
    input  logic                   popSig,
    input  logic [WIDTH-1:0]       pushData,
    output logic [WIDTH-1:0]       popData,
    output logic                   readySig,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t           state_q, state_d;
    logic             push_q, push_d, pop_q, pop_d;
    logic [WIDTH-1:0] data_q, data_d, pop_data_q, pop_data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d, ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_en;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty    = count_q == '0;
    assign full     = count_q == CW'(DEPTH);
    assign wr_idx   = count_q[AW-1:0];
    assign rd_idx   = AW'(count_q - CW'(1));
    assign popData  = pop_data_q;
    assign readySig = ready_q;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;
    always_comb begin
        state_d    = state_q;
        push_d     = push_q;
        pop_d      = pop_q;
        data_d     = data_q;
        pop_data_d = pop_data_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        ready_d    = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: if (pushSig || popSig) begin
                push_d  = pushSig;
                pop_d   = popSig;
                data_d  = pushData;
                state_d = ACCESS;
            end
            ACCESS: begin
                state_d = DONE;
                ready_d = 1'b1;
                // simultaneous push+pop is illegal: flag it, touch nothing else
                if (push_q && pop_q) udf_d = 1'b1;
                else if (push_q) begin
                    if (full) ovf_d = 1'b1;
                    else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end else if (empty) begin
                    udf_d      = 1'b1;
                    pop_data_d = '0;
                end else begin
                    pop_data_d = mem[rd_idx];
                    count_d    = count_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pop_data_q <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
        push_q <= push_d;
        pop_q  <= pop_d;
        data_q <= data_d;
    end
    // storage is not reset; a reset during ACCESS suppresses the write
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_idx] <= data_q;
    end
endmodule

// File: tb/tb_fib_stack.sv
// tb_fib_stack: directed self-checking bench for fib_stack
module tb_fib_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pushSig = 1'b0;
    logic        popSig = 1'b0;
    logic [15:0] pushData = '0;
    logic [15:0] popData;
    logic        readySig;
    logic [4:0]  count;
    logic        empty, full, ovf, udf;
    int          n_vec = 0;
    int          n_bad = 0;

    fib_stack #(.WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .pushSig(pushSig), .popSig(popSig), .pushData(pushData),
        .popData(popData), .readySig(readySig), .count(count), .empty(empty),
        .full(full), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // drive a request, wait (bounded) for readySig, release, confirm single-cycle pulse
    task automatic op(input logic ps, input logic pp, input logic [15:0] d, input string tag);
        int n = 0;
        pushSig  = ps;
        popSig   = pp;
        pushData = d;
        do begin
            @(negedge clk);
            n++;
        end while (!readySig && n < 6);
        pushSig = 1'b0;
        popSig  = 1'b0;
        chk({tag, "_lat"}, n, 2);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, readySig}, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", readySig, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_popdata", popData, 0);

        op(1, 0, 16'h0501, "push1");
        chk("push1_count", count, 1);
        chk("push1_empty", empty, 0);
        op(1, 0, 16'h0402, "push2");
        op(1, 0, 16'h0301, "push3");
        op(0, 1, 16'h0000, "pop1");
        chk("pop1_data", popData, 16'h0301);
        op(0, 1, 16'h0000, "pop2");
        chk("pop2_data", popData, 16'h0402);
        op(0, 1, 16'h0000, "pop3");
        chk("pop3_data", popData, 16'h0501);
        chk("lifo_count", count, 0);
        chk("lifo_empty", empty, 1);
        chk("lifo_udf", udf, 0);

        for (int i = 0; i < 16; i++) op(1, 0, 16'h1000 + 16'(i), "fill");
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        chk("fill_ovf", ovf, 0);
        op(1, 0, 16'hFFFF, "ovpush");
        chk("ov_ovf", ovf, 1);
        chk("ov_count", count, 16);
        chk("ov_full", full, 1);
        for (int i = 15; i >= 0; i--) begin
            op(0, 1, 16'h0000, "drain");
            chk("drain_data", popData, 16'h1000 + 16'(i));
            chk("drain_count", count, 32'(i));
        end
        chk("drain_empty", empty, 1);
        chk("drain_udf", udf, 0);
        chk("drain_ovf", ovf, 1);

        op(0, 1, 16'h0000, "udpop");
        chk("ud_data", popData, 0);
        chk("ud_udf", udf, 1);
        chk("ud_count", count, 0);
        op(1, 0, 16'h0501, "udpush");
        op(0, 1, 16'h0000, "udpop2");
        chk("ud_valid_data", popData, 16'h0501);
        chk("ud_sticky", udf, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_udf", udf, 0);
        chk("rst2_ovf", ovf, 0);
        op(1, 0, 16'h0AAA, "ilA");
        op(1, 0, 16'h0BBB, "ilB");
        op(1, 0, 16'h0CCC, "ilC");
        op(0, 1, 16'h0000, "ilpop");
        chk("il_pre_data", popData, 16'h0CCC);
        chk("il_pre_udf", udf, 0);
        op(1, 1, 16'h0DDD, "illegal");
        chk("il_udf", udf, 1);
        chk("il_count", count, 2);
        chk("il_data", popData, 16'h0CCC);
        op(0, 1, 16'h0000, "ilpop2");
        chk("il_lifo", popData, 16'h0BBB);

        pushSig  = 1'b1;
        pushData = 16'h1234;
        @(negedge clk);
        rst     = 1'b1;
        pushSig = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", readySig, 0);
        chk("abort_count", count, 0);
        chk("abort_data", popData, 0);
        @(negedge clk);
        chk("abort_ready2", readySig, 0);
        op(1, 0, 16'h2222, "post");
        chk("post_count", count, 1);
        op(0, 1, 16'h0000, "postpop");
        chk("post_data", popData, 16'h2222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
